// File: rtl/filter_job_sequencer.sv
// Job-level controller for the masked 2D WOS filter: validates a job, hands the image RAM
// between host and filter, runs the address handler and reports done/error. Macro PERF_CNT_EN adds the RUN cycle counter.
module filter_job_sequencer #(
  parameter int WORD           = 9,
  parameter int MAX_N          = 25,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [WORD-1:0] i_cfg_h,
  input  logic [WORD-1:0] i_cfg_w,
  input  logic [WORD-1:0] i_cfg_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_host_req,
  output logic            o_host_grant,
  output logic            o_mem_sel,
  output logic            o_run,
  output logic [WORD-1:0] o_h_q,
  output logic [WORD-1:0] o_w_q,
  output logic [WORD-1:0] o_n_q,
  input  logic            i_ah_w_en,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [2:0]      o_err_code,
  output logic [WORD+1:0] o_pix_count,
  output logic [31:0]     o_cycle_count
);

  localparam int AW = 2 * WORD;
  localparam int PW = WORD + 2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [AW-1:0] MAX_AREA = AW'(2 ** (WORD + 1));

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_BAD_N = 3'd1;
  localparam logic [2:0] E_ZERO  = 3'd2;
  localparam logic [2:0] E_SIZE  = 3'd3;
  localparam logic [2:0] E_TMO   = 3'd4;
  localparam logic [2:0] E_ABORT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            r_host_grant, r_mem_sel, r_run, r_busy, r_done, r_err;
  logic [2:0]      r_err_code, r_pend_code;
  logic [2:0]      w_err_code_nx, w_pend_nx;
  logic [WORD-1:0] r_h_q, r_w_q, r_n_q;
  logic [PW-1:0]   r_pix_count;
  logic [TW-1:0]   r_idle_cnt;
  logic [DW-1:0]   r_drain_cnt;
  logic [AW-1:0]   w_area;
  logic            w_start, w_last_wr, w_pix_full, w_timeout;
  logic            w_bad_n, w_zero, w_too_big, w_count_wr;

  assign w_area     = AW'(r_h_q) * AW'(r_w_q);
  assign w_start    = i_start & ((r_state == S_IDLE) | (r_state == S_ERROR));
  assign w_last_wr  = i_ah_w_en & (AW'(r_pix_count) == (w_area - AW'(1)));
  assign w_pix_full = AW'(r_pix_count) >= w_area;
  assign w_timeout  = ~i_ah_w_en & (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_bad_n    = ~r_n_q[0] | (r_n_q > WORD'(MAX_N));
  assign w_zero     = (r_h_q == '0) | (r_w_q == '0);
  assign w_too_big  = w_area > MAX_AREA;
  assign w_count_wr = i_ah_w_en & ((r_state == S_RUN) | (r_state == S_DRAIN)) & ~w_pix_full;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state, pending-code and error-code decode; validation order sets error priority
  always_comb begin
    w_state_nx    = r_state;
    w_pend_nx     = r_pend_code;
    w_err_code_nx = r_err_code;
    case (r_state)
      S_IDLE, S_ERROR: begin
        if (i_start) begin
          w_state_nx    = S_CHECK;
          w_pend_nx     = E_NONE;
          w_err_code_nx = E_NONE;
        end else begin
          w_state_nx = r_state;
        end
      end
      S_CHECK: begin
        if (w_bad_n) begin
          w_state_nx    = S_ERROR;
          w_err_code_nx = E_BAD_N;
        end else if (w_zero) begin
          w_state_nx    = S_ERROR;
          w_err_code_nx = E_ZERO;
        end else if (w_too_big) begin
          w_state_nx    = S_ERROR;
          w_err_code_nx = E_SIZE;
        end else begin
          w_state_nx = S_ARM;
        end
      end
      S_ARM: begin
        if (!i_host_req) begin
          w_state_nx = S_RUN;
        end else begin
          w_state_nx = S_ARM;
        end
      end
      S_RUN: begin
        if (w_last_wr) begin
          w_state_nx = S_DRAIN;
        end else if (i_abort) begin
          w_state_nx = S_DRAIN;
          w_pend_nx  = E_ABORT;
        end else if (w_timeout) begin
          w_state_nx = S_DRAIN;
          w_pend_nx  = E_TMO;
        end else begin
          w_state_nx = S_RUN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
          if (r_pend_code == E_NONE) begin
            w_state_nx = S_DONE;
          end else begin
            w_state_nx    = S_ERROR;
            w_err_code_nx = r_pend_code;
          end
        end else begin
          w_state_nx = S_DRAIN;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx    = S_IDLE;
        w_pend_nx     = E_NONE;
        w_err_code_nx = E_NONE;
      end
    endcase
  end

  // Status outputs registered from the next state so they align with the state they describe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_host_grant <= 1'b0;
      r_mem_sel    <= 1'b0;
      r_run        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= E_NONE;
      r_pend_code  <= E_NONE;
    end else begin
      r_host_grant <= i_host_req & ((w_state_nx == S_IDLE) | (w_state_nx == S_ERROR));
      r_mem_sel    <= (w_state_nx == S_RUN) | (w_state_nx == S_DRAIN);
      r_run        <= (w_state_nx == S_RUN);
      r_busy       <= ~((w_state_nx == S_IDLE) | (w_state_nx == S_ERROR));
      r_done       <= (w_state_nx == S_DONE);
      r_err        <= (w_state_nx == S_ERROR);
      r_err_code   <= w_err_code_nx;
      r_pend_code  <= w_pend_nx;
    end
  end

  // Job datapath: config latch, saturating write count, idle and drain timers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_q       <= '0;
      r_w_q       <= '0;
      r_n_q       <= '0;
      r_pix_count <= '0;
      r_idle_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_start) begin
        r_h_q       <= i_cfg_h;
        r_w_q       <= i_cfg_w;
        r_n_q       <= i_cfg_n;
        r_pix_count <= '0;
      end else if (w_count_wr) begin
        r_pix_count <= r_pix_count + PW'(1);
      end else begin
        r_pix_count <= r_pix_count;
      end
      if ((r_state == S_RUN) && !i_ah_w_en) begin
        r_idle_cnt <= r_idle_cnt + TW'(1);
      end else begin
        r_idle_cnt <= '0;
      end
      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + DW'(1);
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_cycle_count;

  // RUN-phase cycle counter, held after the job until the next accepted start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle_count <= 32'd0;
    end else if (w_start) begin
      r_cycle_count <= 32'd0;
    end else if (r_state == S_RUN) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end else begin
      r_cycle_count <= r_cycle_count;
    end
  end

  assign o_cycle_count = r_cycle_count;
`else
  assign o_cycle_count = 32'd0;
`endif

  assign o_host_grant = r_host_grant;
  assign o_mem_sel    = r_mem_sel;
  assign o_run        = r_run;
  assign o_h_q        = r_h_q;
  assign o_w_q        = r_w_q;
  assign o_n_q        = r_n_q;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_pix_count  = r_pix_count;

endmodule

// File: tb/tb_filter_job_sequencer.sv
// Scoreboard bench for filter_job_sequencer: jobs are planned up front, their outcome is
// derived from the job rules and queued, and a negedge monitor compares every job completion.
module tb_filter_job_sequencer;
  localparam int WORD  = 9;
  localparam int MAX_N = 25;
  localparam int DRAIN = 4;
  localparam int TMO   = 16;

  logic            clk, rst, start, abort_i, host_req, ah_w_en;
  logic [WORD-1:0] cfg_h, cfg_w, cfg_n;
  logic            host_grant, mem_sel, run, busy, done, err;
  logic [WORD-1:0] h_q, w_q, n_q;
  logic [2:0]      err_code;
  logic [WORD+1:0] pix_count;
  logic [31:0]     cycle_count;

  filter_job_sequencer #(.WORD(WORD), .MAX_N(MAX_N), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_h(cfg_h), .i_cfg_w(cfg_w), .i_cfg_n(cfg_n),
    .i_start(start), .i_abort(abort_i), .i_host_req(host_req),
    .o_host_grant(host_grant), .o_mem_sel(mem_sel), .o_run(run),
    .o_h_q(h_q), .o_w_q(w_q), .o_n_q(n_q), .i_ah_w_en(ah_w_en),
    .o_busy(busy), .o_done(done), .o_err(err), .o_err_code(err_code),
    .o_pix_count(pix_count), .o_cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit is_err;
    int code;
    int pix;
    bit ran;
    int cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cfg_code(input int h, input int w, input int n);
    if ((n % 2) == 0 || n > MAX_N) return 1;
    if (h == 0 || w == 0) return 2;
    if (h * w > (1 << (WORD + 1))) return 3;
    return 0;
  endfunction

  // Monitor: exclusivity every cycle, and one scoreboard pop per job completion
  bit saw_run, prev_err, prev_done;
  int drain_seen;
  always @(negedge clk) begin
    if (rst) begin
      saw_run = 1'b0; drain_seen = 0; prev_err = 1'b0; prev_done = 1'b0;
    end else begin
      chk("grant_memsel_exclusive", host_grant & mem_sel, 0);
      if (run) saw_run = 1'b1;
      if (mem_sel && !run) drain_seen++;
      if (done) chk("done_single_cycle", prev_done, 0);
      if (done || (err && !prev_err)) begin
        bit have;
        exp_t e;
        have = (sb.size() != 0);
        chk("completion_expected", have, 1);
        if (have) begin
          e = sb.pop_front();
          chk("end_kind_err", err, e.is_err);
          chk("err_code", err_code, e.code);
          chk("pix_count", pix_count, e.pix);
          chk("run_asserted", saw_run, e.ran);
          chk("drain_cycles", drain_seen, e.ran ? DRAIN : 0);
          chk("cycle_count", cycle_count, e.cyc);
        end
        saw_run = 1'b0;
        drain_seen = 0;
      end
      prev_err = err;
      prev_done = done;
    end
  end

  // mode 0: complete (plus 2 extra writes in drain), 1: abort after a writes, 2: stall after a writes
  task automatic run_job(input int h, input int w, input int n, input int mode,
                         input int a, input int hold, input int gap);
    int   code, total, cur, last_w, abort_idx, end_idx, nw, k;
    bit   wr[int];
    exp_t e;
    code = cfg_code(h, w, n);
    total = h * w;
    abort_idx = -1;
    end_idx = -1;
    last_w = -1;
    if (code == 0) begin
      cur = (gap > 0) ? 0 : int'($urandom_range(0, 3));
      nw = (mode == 0) ? total : a;
      for (int i = 0; i < nw; i++) begin
        wr[cur] = 1'b1;
        last_w = cur;
        cur += (gap > 0) ? gap : int'($urandom_range(1, 4));
      end
      end_idx = last_w;
      e.ran = 1'b1;
      if (mode == 0) begin
        e.code = 0; e.pix = total; e.cyc = last_w + 1;
        wr[last_w + 1] = 1'b1;
        wr[last_w + 2] = 1'b1;
        end_idx = last_w + 2;
      end else if (mode == 1) begin
        abort_idx = cur;
        end_idx = cur;
        e.code = 5; e.pix = a; e.cyc = cur + 1;
      end else begin
        e.code = 4; e.pix = a; e.cyc = (last_w < 0) ? TMO : last_w + TMO + 1;
      end
      e.is_err = (e.code != 0);
    end else begin
      e.is_err = 1'b1; e.code = code; e.pix = 0; e.ran = 1'b0; e.cyc = 0;
    end
`ifndef PERF_CNT_EN
    e.cyc = 0;
`endif
    sb.push_back(e);

    cfg_h = WORD'(h); cfg_w = WORD'(w); cfg_n = WORD'(n);
    start = 1'b1;
    host_req = (hold > 0);
    step();
    start = 1'b0;
    for (int i = 1; i < hold; i++) begin
      if (code == 0) begin
        chk("arm_grant_low", host_grant, 0);
        chk("arm_memsel_low", mem_sel, 0);
      end
      step();
    end
    host_req = 1'b0;
    if (code == 0 && hold >= 2) begin
      chk("memsel_in_first_low_cycle", mem_sel, 0);
      step();
      chk("memsel_after_first_low_cycle", mem_sel, 1);
      chk("grant_when_memsel", host_grant, 0);
    end
    if (code == 0) begin
      k = 0;
      while (!run && k < 40) begin step(); k++; end
      chk("run_seen", run, 1);
      if (run) begin
        for (int i = 0; i <= end_idx; i++) begin
          ah_w_en = wr.exists(i);
          abort_i = (i == abort_idx);
          step();
          if (i == abort_idx) chk("run_drop_abort", run, 0);
          if (mode == 0 && i == last_w) chk("run_drop_last", run, 0);
        end
      end
      ah_w_en = 1'b0;
      abort_i = 1'b0;
    end
    k = 0;
    while (busy && k < 200) begin step(); k++; end
    chk("job_terminates", busy, 0);
    step();
  endtask

  initial begin
    int h, w, n, total;
    rst = 1'b1; start = 1'b0; abort_i = 1'b0; host_req = 1'b0; ah_w_en = 1'b0;
    cfg_h = '0; cfg_w = '0; cfg_n = '0;
    step();
    step();
    chk("rst_grant", host_grant, 0);
    chk("rst_memsel", mem_sel, 0);
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_pix", pix_count, 0);
    chk("rst_hq", h_q, 0);
    chk("rst_cycles", cycle_count, 0);
    rst = 1'b0;
    host_req = 1'b1;
    step();
    chk("idle_grant_follows_req", host_grant, 1);
    host_req = 1'b0;
    step();
    chk("idle_grant_drops", host_grant, 0);

    run_job(4, 5, 3, 0, 0, 0, 3);
    chk("latched_w", w_q, 5);
    run_job(4, 5, 4, 0, 0, 0, 0);
    run_job(0, 5, 3, 0, 0, 0, 0);
    run_job(33, 32, 3, 0, 0, 0, 0);
    run_job(5, 5, 27, 0, 0, 0, 0);
    run_job(4, 5, 3, 0, 0, 5, 0);
    run_job(4, 5, 3, 1, 7, 0, 3);
    run_job(4, 5, 3, 2, 0, 0, 0);
    run_job(4, 5, 3, 2, 5, 0, 0);
    run_job(32, 32, 25, 0, 0, 0, 1);
    run_job(1, 1, 1, 0, 0, 2, 0);

    // reset in the middle of RUN
    cfg_h = 9'd4; cfg_w = 9'd5; cfg_n = 9'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && !run; i++) step();
    chk("mid_rst_run_seen", run, 1);
    ah_w_en = 1'b1;
    step(); step(); step();
    ah_w_en = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_run", run, 0);
    chk("mid_rst_memsel", mem_sel, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pix", pix_count, 0);
    chk("mid_rst_hq", h_q, 0);
    chk("mid_rst_cycles", cycle_count, 0);
    rst = 1'b0;
    step();

    for (int j = 0; j < 14; j++) begin
      h = $urandom_range(0, 6);
      w = $urandom_range(0, 6);
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 30)) : 2 * int'($urandom_range(0, 12)) + 1;
      total = h * w;
      run_job(h, w, n, $urandom_range(0, 2), (total > 0) ? int'($urandom_range(0, total - 1)) : 0,
              $urandom_range(0, 4), 0);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/filter_job_sequencer.md
Name: filter_job_sequencer

Overview:
Job-level controller for the masked 2D WOS filter. Accepts a host job request (frame height, width, kernel size), validates it, and arbitrates the shared image RAM between the host load/readback port and the filter address handler. It then drives the handler's run level, counts completed output writes, and reports done, error or abort. Sits between the host register interface and the address handler / image RAM mux.

Parameters:
WORD, 9, width of h/w/n config fields; RAM address width is WORD+1
MAX_N, 25, largest legal kernel size
DRAIN_CYCLES, 4, cycles held after last write so pipelined writes land before RAM is returned to host
TIMEOUT_CYCLES, 65535, max RUN cycles without an output write before error

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_h  in  WORD  frame height
cfg_w  in  WORD  frame width
cfg_n  in  WORD  kernel size
start  in  1  one-cycle job request
abort  in  1  one-cycle abort request
host_req  in  1  host wants the image RAM
host_grant  out  1  host owns the image RAM this cycle
mem_sel  out  1  RAM mux select: 0 = host, 1 = filter
run  out  1  level run to address handler
h_q, w_q, n_q  out  WORD each  latched config to address handler
ah_w_en  in  1  output-write strobe from address handler
busy  out  1  state not IDLE/ERROR
done  out  1  one-cycle job-complete pulse
err  out  1  sticky error flag
err_code  out  3  1 bad n, 2 zero h/w, 3 frame too large, 4 timeout, 5 aborted
pix_count  out  WORD+2  output writes counted in current/last job
cycle_count  out  32  RUN-phase cycle count (see Optional Feature)

Behaviour:
- Reset values: state IDLE; run 0, mem_sel 0, host_grant 0, busy 0, done 0, err 0, err_code 0, pix_count 0, h_q/w_q/n_q 0, cycle_count 0. rst mid-job drops run and mem_sel on the next edge.
- IDLE: host_grant registered from host_req, one cycle latency. On start, latch cfg into *_q, clear pix_count, err, err_code, go CHECK.
- ERROR: same host arbitration as IDLE, err held. start behaves as in IDLE. start sampled in any other state is ignored.
- CHECK (1 cycle) validation, first failure wins:
  - n even, n==0, or n>MAX_N -> ERROR code 1.
  - h==0 or w==0 -> ERROR code 2.
  - h*w > 2^(WORD+1) -> ERROR code 3. Product computed at 2*WORD bits.
  - Otherwise -> ARM.
- ARM: host_grant forced 0. Wait until host_req==0 for one full cycle, then set mem_sel=1 and go RUN on the following edge. The host is never preempted mid-access.
- RUN: run=1, mem_sel=1.
  - Each ah_w_en increments pix_count.
  - When ah_w_en arrives with pix_count==h*w-1 -> DRAIN.
  - abort -> DRAIN with err_code 5 pending.
  - Idle counter resets on each ah_w_en; reaching TIMEOUT_CYCLES -> DRAIN with code 4 pending.
  - abort and final write in the same cycle: completion wins.
- DRAIN: run=0, mem_sel stays 1 for DRAIN_CYCLES cycles. ah_w_en still counted, saturating at h*w. Then go DONE if nothing is pending, else ERROR with err=1 and the pending code.
- DONE: done=1 for exactly one cycle, mem_sel=0, next state IDLE.
- busy=1 in CHECK, ARM, RUN, DRAIN, DONE.
- host_grant and mem_sel are never both 1.

Optional Feature:
PERF_CNT_EN.
- Defined: cycle_count clears on start and increments every RUN cycle; it holds through DRAIN/DONE/ERROR until the next start.
- Undefined: no counter logic is built and cycle_count is tied to 0.

Test Plan:
- Valid job: h=4, w=5, n=3, start, then 20 ah_w_en pulses one per 3 cycles -> run high in RUN, DRAIN 4 cycles, single done pulse, pix_count=20, err=0.
- Config errors: n=4 -> err=1 code 1, run never asserted; h=0 -> code 2; h=33, w=32 with WORD=9 -> code 3.
- Arbitration: host_req held high across start -> ARM waits, host_grant=0, mem_sel=0 until host_req drops; mem_sel rises exactly one cycle after the first low cycle, and host_grant never coincides with mem_sel.
- Abort: abort after 7 writes of a 20-write job -> run drops next edge, DRAIN, err_code 5, pix_count=7, no done.
- Timeout: TIMEOUT_CYCLES=16, no ah_w_en -> err_code 4 after 16 RUN cycles. rst asserted mid-RUN -> all outputs at reset values after one edge.
- PERF_CNT_EN defined: 20 writes one per 3 cycles -> cycle_count=60±2 after done; undefined -> cycle_count stays 0.
